wb_bus_supervisor: RTL and testbench

Bus supervisor placed between the 4-master Wishbone arbiter/mux and the shared slave side. It watches the currently granted cycle and aborts any strobe that stalls longer than TIMEOUT cycles by returning an error to the master. It enforces a per-tenure beat quota by requesting the arbiter to hand over the bus. It also keeps a sticky timeout record (flag, offending master, count) for software.

---
 rtl/wb_bus_supervisor.sv | 139 +++++++++++++
 tb/tb_wb_bus_supervisor.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/wb_bus_supervisor.sv
// Wishbone bus supervisor: aborts stalled strobes with an error, enforces a per-tenure
// beat quota via YIELD, and keeps a sticky timeout record for software.
module wb_bus_supervisor #(
  parameter int unsigned TW      = 8,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned QUOTA   = 16
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          CYC,
  input  logic [1:0]    GNT,
  input  logic          STB_I,
  input  logic          ACK_I,
  input  logic          ERR_I,
  input  logic          CLR_I,
  output logic          ACK_O,
  output logic          ERR_O,
  output logic          YIELD,
  output logic          TO_FLAG,
  output logic [1:0]    TO_MASTER,
  output logic [TW-1:0] TO_COUNT
);

  localparam int unsigned BW      = (QUOTA > 0) ? $clog2(QUOTA + 1) : 1;
  localparam logic [TW-1:0] WLast  = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] CntMax = '1;
  localparam logic [BW-1:0] QuotaB = BW'(QUOTA);
  localparam bit QuotaEn = (QUOTA != 0);

  typedef enum logic [1:0] {StIdle, StActive, StAbort} state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] w_q, w_d;
  logic [BW-1:0] b_q, b_d;
  logic          abort_q, abort_d;
  logic          yield_q, yield_d;
  logic [1:0]    gnt_prev_q, gnt_prev_d;
  logic          to_flag_q, to_flag_d;
  logic [1:0]    to_master_q, to_master_d;
  logic [TW-1:0] to_count_q, to_count_d;

  logic          gnt_chg, live, stall, timeout, beat, bump;
  logic [TW-1:0] w_eff;
  logic [BW-1:0] b_eff, b_inc;
  logic          yield_eff;

  always_comb begin
    // A grant change under CYC starts a new tenure: counters restart this very cycle.
    gnt_chg   = CYC && (GNT != gnt_prev_q);
    live      = CYC && (state_q != StAbort);
    stall     = live && STB_I && !ACK_I && !ERR_I;
    w_eff     = gnt_chg ? '0 : w_q;
    b_eff     = gnt_chg ? '0 : b_q;
    yield_eff = gnt_chg ? 1'b0 : yield_q;
    timeout   = stall && (w_eff == WLast);
    beat      = live && ACK_I;
    bump      = beat && QuotaEn && (b_eff != QuotaB);
    b_inc     = b_eff + BW'(1);

    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (timeout) state_d = StAbort;
        else if (CYC) state_d = StActive;
      end
      StActive: begin
        if (!CYC) state_d = StIdle;
        else if (timeout) state_d = StAbort;
      end
      StAbort: begin
        if (!CYC) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    w_d        = (stall && !timeout) ? w_eff + TW'(1) : '0;
    abort_d    = timeout;
    gnt_prev_d = GNT;

    if (!CYC) begin
      b_d     = '0;
      yield_d = 1'b0;
    end else begin
      b_d     = bump ? b_inc : b_eff;
      yield_d = yield_eff || (bump && (b_inc == QuotaB));
    end

    to_flag_d   = to_flag_q;
    to_master_d = to_master_q;
    to_count_d  = to_count_q;
    if (CLR_I) begin
      to_flag_d   = 1'b0;
      to_master_d = '0;
      to_count_d  = '0;
    end
    // Recording a timeout takes priority over a coincident clear.
    if (timeout) begin
      to_flag_d   = 1'b1;
      to_master_d = GNT;
      if (CLR_I) to_count_d = TW'(1);
      else if (to_count_q != CntMax) to_count_d = to_count_q + TW'(1);
      else to_count_d = CntMax;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StIdle;
      w_q         <= '0;
      b_q         <= '0;
      abort_q     <= 1'b0;
      yield_q     <= 1'b0;
      gnt_prev_q  <= '0;
      to_flag_q   <= 1'b0;
      to_master_q <= '0;
      to_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      w_q         <= w_d;
      b_q         <= b_d;
      abort_q     <= abort_d;
      yield_q     <= yield_d;
      gnt_prev_q  <= gnt_prev_d;
      to_flag_q   <= to_flag_d;
      to_master_q <= to_master_d;
      to_count_q  <= to_count_d;
    end
  end

  always_comb begin
    ACK_O     = ACK_I && (state_q != StAbort);
    ERR_O     = (ERR_I && (state_q != StAbort)) || abort_q;
    YIELD     = yield_q;
    TO_FLAG   = to_flag_q;
    TO_MASTER = to_master_q;
    TO_COUNT  = to_count_q;
  end

endmodule

// File: tb/tb_wb_bus_supervisor.sv
// Scoreboard bench for wb_bus_supervisor: two instances (QUOTA=3 and QUOTA=0, TIMEOUT=4)
// share stimulus; each directed cycle queues its expected outputs for a negedge monitor.
module tb_wb_bus_supervisor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cyc = 1'b0;
  logic [1:0] gnt = 2'd0;
  logic       stb = 1'b0, ack = 1'b0, err = 1'b0, clr = 1'b0;

  logic       ack_o0, err_o0, yield0, flag0;
  logic [1:0] master0;
  logic [7:0] count0;
  logic       ack_o1, err_o1, yield1, flag1;
  logic [1:0] master1;
  logic [7:0] count1;

  always #5 clk = ~clk;

  wb_bus_supervisor #(.TW(8), .TIMEOUT(4), .QUOTA(3)) dut0 (
    .CLK(clk), .RST(rst), .CYC(cyc), .GNT(gnt), .STB_I(stb), .ACK_I(ack), .ERR_I(err),
    .CLR_I(clr), .ACK_O(ack_o0), .ERR_O(err_o0), .YIELD(yield0), .TO_FLAG(flag0),
    .TO_MASTER(master0), .TO_COUNT(count0)
  );

  wb_bus_supervisor #(.TW(8), .TIMEOUT(4), .QUOTA(0)) dut1 (
    .CLK(clk), .RST(rst), .CYC(cyc), .GNT(gnt), .STB_I(stb), .ACK_I(ack), .ERR_I(err),
    .CLR_I(clr), .ACK_O(ack_o1), .ERR_O(err_o1), .YIELD(yield1), .TO_FLAG(flag1),
    .TO_MASTER(master1), .TO_COUNT(count1)
  );

  typedef struct {
    logic       ack;
    logic       err;
    logic       y0;
    logic       y1;
    logic       flag;
    logic [1:0] master;
    logic [7:0] count;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;

  // Expected sticky timeout record, updated by hand where a timeout is due.
  logic       ef = 1'b0;
  logic [1:0] em = 2'd0;
  logic [7:0] ec = 8'd0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, want);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("ack_o",     {7'd0, ack_o0},  {7'd0, e.ack});
      check("err_o",     {7'd0, err_o0},  {7'd0, e.err});
      check("yield_q3",  {7'd0, yield0},  {7'd0, e.y0});
      check("to_flag",   {7'd0, flag0},   {7'd0, e.flag});
      check("to_master", {6'd0, master0}, {6'd0, e.master});
      check("to_count",  count0,          e.count);
      check("yield_q0",  {7'd0, yield1},  {7'd0, e.y1});
      check("err_o_q0",  {7'd0, err_o1},  {7'd0, e.err});
      check("to_count_q0", count1,        e.count);
    end
  end

  task automatic step(input logic r, input logic c, input logic [1:0] g, input logic s,
                      input logic a, input logic e, input logic cl, input logic ea,
                      input logic ee, input logic ey, input logic ey1);
    exp_t x;
    @(posedge clk);
    #1;
    rst = r; cyc = c; gnt = g; stb = s; ack = a; err = e; clr = cl;
    x.ack = ea; x.err = ee; x.y0 = ey; x.y1 = ey1;
    x.flag = ef; x.master = em; x.count = ec;
    exp_q.push_back(x);
  endtask

  // n stalled cycles with strobe held and no slave response.
  task automatic stall(input logic [1:0] g, input int n);
    for (int k = 0; k < n; k++) step(0, 1, g, 1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic note_timeout(input logic [1:0] g);
    ef = 1'b1;
    em = g;
    ec = (ec == 8'd255) ? 8'd255 : ec + 8'd1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    step(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);

    // Timeout: error only in cycle 4, late ACK blocked, drop CYC to leave ABORT.
    stall(1, 4);
    note_timeout(1);
    step(0, 1, 1, 1, 0, 0, 0, 0, 1, 0, 0);
    step(0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);

    // ACK on the last tolerated stall cycle wins.
    stall(1, 3);
    step(0, 1, 1, 1, 1, 0, 0, 1, 0, 0, 0);
    step(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);

    // ERR_I on the last tolerated stall cycle passes through, no abort.
    stall(1, 3);
    step(0, 1, 1, 1, 0, 1, 0, 0, 1, 0, 0);
    step(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);

    // Quota: 20 ACKs on master 2; YIELD from cycle 3 with QUOTA=3, never with QUOTA=0.
    step(0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 1, 2, 1, 1, 0, 0, 1, 0, (i >= 3), 0);
    step(0, 1, 2, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 2, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0);

    // Tenure change 1->3 after 2 ACKs restarts the beat count.
    step(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 1, 1, 0, 0, 1, 0, 0, 0);
    step(0, 1, 1, 1, 1, 0, 0, 1, 0, 0, 0);
    step(0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 3, 1, 1, 0, 0, 1, 0, 0, 0);
    step(0, 1, 3, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 3, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0);

    // Clear, then 256 timeouts: count saturates at 255.
    step(0, 0, 3, 0, 0, 0, 1, 0, 0, 0, 0);
    ef = 1'b0; em = 2'd0; ec = 8'd0;
    for (int i = 0; i < 256; i++) begin
      logic [1:0] g;
      g = 2'(i);
      step(0, 0, g, 0, 0, 0, 0, 0, 0, 0, 0);
      stall(g, 4);
      note_timeout(g);
      step(0, 1, g, 1, 0, 0, 0, 0, 1, 0, 0);
    end
    step(0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0);

    // Clear coincident with a timeout: set wins, count restarts at 1.
    step(0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    stall(2, 3);
    step(0, 1, 2, 1, 0, 0, 1, 0, 0, 0, 0);
    ef = 1'b1; em = 2'd2; ec = 8'd1;
    step(0, 1, 2, 1, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset during ABORT: next cycle back in IDLE, so ACK passes again.
    step(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    stall(1, 4);
    note_timeout(1);
    step(0, 1, 1, 1, 0, 0, 0, 0, 1, 0, 0);
    step(1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    ef = 1'b0; em = 2'd0; ec = 8'd0;
    step(0, 1, 1, 0, 1, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset during a 3-cycle stall: no error pulse, stall count restarts.
    stall(0, 3);
    step(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    stall(0, 3);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    repeat (3) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
